// File: rtl/seg7_to_bin.sv
// seg7_to_bin: recovers {nibble1,nibble0} from two active-low 7-seg codes once both are stable for STABLE_CYCLES; result held until out_ready.
// Latency STABLE_CYCLES edges after capture (+2 with SEG7_SYNC_EN, which adds a 2-flop input synchronizer).
module seg7_to_bin #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg0_in,
  input  logic [7:0] seg1_in,
  input  logic       out_ready,
  output logic [7:0] bin_out,
  output logic       out_valid,
  output logic       out_err
);

  typedef enum logic [1:0] {WAIT_CHG, SETTLE, HOLD} state_t;

  localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0] BLANK    = 7'h7F;

  logic [7:0] seg0_s, seg1_s;

`ifdef SEG7_SYNC_EN
  logic [7:0] seg0_m_q, seg0_s_q, seg1_m_q, seg1_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg0_m_q <= 8'hFF;
      seg0_s_q <= 8'hFF;
      seg1_m_q <= 8'hFF;
      seg1_s_q <= 8'hFF;
    end else begin
      seg0_m_q <= seg0_in;
      seg0_s_q <= seg0_m_q;
      seg1_m_q <= seg1_in;
      seg1_s_q <= seg1_m_q;
    end
  end

  assign seg0_s = seg0_s_q;
  assign seg1_s = seg1_s_q;
`else
  assign seg0_s = seg0_in;
  assign seg1_s = seg1_in;
`endif

  state_t     state_q;
  logic [7:0] snap0_q, snap1_q, cnt_q;
  logic [7:0] bin_q;
  logic       vld_q, err_q;

  // Returns {legal, nibble}; illegal glyphs decode to nibble 0.
  function automatic logic [4:0] dec(input logic [6:0] s);
    case (s)
      7'h40:   dec = 5'h10;
      7'h79:   dec = 5'h11;
      7'h24:   dec = 5'h12;
      7'h30:   dec = 5'h13;
      7'h19:   dec = 5'h14;
      7'h12:   dec = 5'h15;
      7'h02:   dec = 5'h16;
      7'h78:   dec = 5'h17;
      7'h00:   dec = 5'h18;
      7'h10:   dec = 5'h19;
      7'h08:   dec = 5'h1A;
      7'h03:   dec = 5'h1B;
      7'h46:   dec = 5'h1C;
      7'h21:   dec = 5'h1D;
      7'h06:   dec = 5'h1E;
      7'h0E:   dec = 5'h1F;
      default: dec = 5'h00;
    endcase
  endfunction

  logic [4:0] dec0, dec1;
  logic       chg, blank, unused_dp;

  assign dec0      = dec(snap0_q[6:0]);
  assign dec1      = dec(snap1_q[6:0]);
  assign chg       = (seg0_s[6:0] != snap0_q[6:0]) || (seg1_s[6:0] != snap1_q[6:0]);
  assign blank     = (snap0_q[6:0] == BLANK) && (snap1_q[6:0] == BLANK);
  assign unused_dp = snap0_q[7] ^ snap1_q[7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_CHG;
      snap0_q <= 8'hFF;
      snap1_q <= 8'hFF;
      cnt_q   <= 8'd0;
      bin_q   <= 8'd0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        WAIT_CHG: begin
          if (chg) begin
            snap0_q <= seg0_s;
            snap1_q <= seg1_s;
            cnt_q   <= 8'd0;
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (chg) begin
            snap0_q <= seg0_s;
            snap1_q <= seg1_s;
            cnt_q   <= 8'd0;
          end else if (cnt_q == LAST_CNT) begin
            if (blank) begin
              state_q <= WAIT_CHG;
            end else begin
              bin_q   <= {dec1[3:0], dec0[3:0]};
              err_q   <= ~(dec1[4] & dec0[4]);
              vld_q   <= 1'b1;
              state_q <= HOLD;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        HOLD: begin
          // Inputs are ignored until the consumer takes the result.
          if (vld_q && out_ready) begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            if (chg) begin
              snap0_q <= seg0_s;
              snap1_q <= seg1_s;
              cnt_q   <= 8'd0;
              state_q <= SETTLE;
            end else begin
              state_q <= WAIT_CHG;
            end
          end
        end
        default: state_q <= WAIT_CHG;
      endcase
    end
  end

  assign bin_out   = bin_q;
  assign out_valid = vld_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_seg7_to_bin.sv
// Directed bench for seg7_to_bin (STABLE_CYCLES=4); inputs driven and outputs sampled 1ns after the rising edge.
`timescale 1ns/1ps
module tb_seg7_to_bin;

`ifdef SEG7_SYNC_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 5;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] seg0 = 8'h7F;
  logic [7:0] seg1 = 8'h7F;
  logic       rdy = 1'b0;
  logic [7:0] bin;
  logic       vld, err;

  int applied = 0;
  int miscompares = 0;

  seg7_to_bin #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg0_in   (seg0),
    .seg1_in   (seg1),
    .out_ready (rdy),
    .bin_out   (bin),
    .out_valid (vld),
    .out_err   (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; seg0 = 8'h7F; seg1 = 8'h7F; rdy = 1'b0;
    #2;
    applied++;
    if (vld !== 1'b0 || bin !== 8'h00 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: vld=%b bin=%h err=%b, want 0/00/0", vld, bin, err);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    applied++;
    if (vld !== 1'b0 || bin !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_release: vld=%b bin=%h, want 0/00", vld, bin);
    end
  endtask

  task automatic test_basic();
    seg1 = 8'h79; seg0 = 8'h40; rdy = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      applied++;
      if (vld !== 1'b0) begin
        miscompares++;
        $display("FAIL basic_early cycle %0d: vld=%b want 0", i, vld);
      end
    end
    tick();
    applied++;
    if (vld !== 1'b1 || bin !== 8'h10 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_report: vld=%b bin=%h err=%b, want 1/10/0", vld, bin, err);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      applied++;
      if (vld !== 1'b0 || bin !== 8'h10) begin
        miscompares++;
        $display("FAIL basic_once cycle %0d: vld=%b bin=%h, want 0/10", i, vld, bin);
      end
    end
  endtask

  task automatic test_backpressure();
    rdy = 1'b0; seg1 = 8'h0E; seg0 = 8'h03;
    for (int i = 0; i < LAT - 1; i++) tick();
    tick();
    applied++;
    if (vld !== 1'b1 || bin !== 8'hFB || err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_report: vld=%b bin=%h err=%b, want 1/FB/0", vld, bin, err);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      applied++;
      if (vld !== 1'b1 || bin !== 8'hFB) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: vld=%b bin=%h, want 1/FB", i, vld, bin);
      end
    end
    seg1 = 8'h00; seg0 = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tick();
      applied++;
      if (vld !== 1'b1 || bin !== 8'hFB) begin
        miscompares++;
        $display("FAIL bp_frozen cycle %0d: vld=%b bin=%h, want 1/FB", i, vld, bin);
      end
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    applied++;
    if (vld !== 1'b0 || bin !== 8'hFB || err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_accept: vld=%b bin=%h err=%b, want 0/FB/0", vld, bin, err);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      applied++;
      if (vld !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_resettle cycle %0d: vld=%b want 0", i, vld);
      end
    end
    tick();
    applied++;
    if (vld !== 1'b1 || bin !== 8'h88 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next: vld=%b bin=%h err=%b, want 1/88/0", vld, bin, err);
    end
    rdy = 1'b1;
    tick();
    applied++;
    if (vld !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_next_accept: vld=%b want 0", vld);
    end
  endtask

  task automatic test_glitch();
    rdy = 1'b1; seg1 = 8'h24;
    for (int k = 0; k < 7; k++) begin
      seg0 = k[0] ? 8'h19 : 8'h12;
      for (int j = 0; j < 2; j++) begin
        tick();
        applied++;
        if (vld !== 1'b0) begin
          miscompares++;
          $display("FAIL glitch_quiet step %0d: vld=%b want 0", k, vld);
        end
      end
    end
    seg0 = 8'h19;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      applied++;
      if (vld !== 1'b0) begin
        miscompares++;
        $display("FAIL glitch_early cycle %0d: vld=%b want 0", i, vld);
      end
    end
    tick();
    applied++;
    if (vld !== 1'b1 || bin !== 8'h24 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL glitch_report: vld=%b bin=%h err=%b, want 1/24/0", vld, bin, err);
    end
    tick();
  endtask

  task automatic test_blank_illegal();
    rst_n = 1'b0; seg1 = 8'h7F; seg0 = 8'h7F; rdy = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      applied++;
      if (vld !== 1'b0) begin
        miscompares++;
        $display("FAIL blank_quiet cycle %0d: vld=%b want 0", i, vld);
      end
    end
    seg1 = 8'h55; seg0 = 8'h30;
    for (int i = 0; i < LAT - 1; i++) tick();
    tick();
    applied++;
    if (vld !== 1'b1 || bin !== 8'h03 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_hi: vld=%b bin=%h err=%b, want 1/03/1", vld, bin, err);
    end
    rdy = 1'b1;
    tick();
    applied++;
    if (vld !== 1'b0 || err !== 1'b0 || bin !== 8'h03) begin
      miscompares++;
      $display("FAIL illegal_accept: vld=%b bin=%h err=%b, want 0/03/0", vld, bin, err);
    end
    seg1 = 8'h06; seg0 = 8'h7E;
    for (int i = 0; i < LAT - 1; i++) tick();
    tick();
    applied++;
    if (vld !== 1'b1 || bin !== 8'hE0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_lo: vld=%b bin=%h err=%b, want 1/E0/1", vld, bin, err);
    end
    tick();
    seg1 = 8'h7F; seg0 = 8'h7F;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      applied++;
      if (vld !== 1'b0) begin
        miscompares++;
        $display("FAIL blank_after_value cycle %0d: vld=%b want 0", i, vld);
      end
    end
  endtask

  task automatic test_reset_midway();
    rdy = 1'b0; seg1 = 8'h40; seg0 = 8'h79;
    for (int i = 0; i < LAT - 2; i++) tick();
    applied++;
    if (vld !== 1'b0 || bin !== 8'hE0) begin
      miscompares++;
      $display("FAIL settle_before_rst: vld=%b bin=%h, want 0/E0", vld, bin);
    end
    rst_n = 1'b0;
    #1;
    applied++;
    if (vld !== 1'b0 || bin !== 8'h00 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL settle_async_rst: vld=%b bin=%h err=%b, want 0/00/0", vld, bin, err);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      applied++;
      if (vld !== 1'b0) begin
        miscompares++;
        $display("FAIL rst1_early cycle %0d: vld=%b want 0", i, vld);
      end
    end
    tick();
    applied++;
    if (vld !== 1'b1 || bin !== 8'h01 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst1_report: vld=%b bin=%h err=%b, want 1/01/0", vld, bin, err);
    end
    tick(); tick();
    rst_n = 1'b0;
    #1;
    applied++;
    if (vld !== 1'b0 || bin !== 8'h00 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_async_rst: vld=%b bin=%h err=%b, want 0/00/0", vld, bin, err);
    end
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < LAT - 1; i++) begin
      tick();
      applied++;
      if (vld !== 1'b0) begin
        miscompares++;
        $display("FAIL rst2_early cycle %0d: vld=%b want 0", i, vld);
      end
    end
    tick();
    applied++;
    if (vld !== 1'b1 || bin !== 8'h01) begin
      miscompares++;
      $display("FAIL rst2_report: vld=%b bin=%h, want 1/01", vld, bin);
    end
    rdy = 1'b1;
    tick();
    applied++;
    if (vld !== 1'b0) begin
      miscompares++;
      $display("FAIL rst2_accept: vld=%b want 0", vld);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_glitch();
    test_blank_illegal();
    test_reset_midway();
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
